// File: rtl/cpu4_core.sv
// cpu4_core: 4-bit accumulator CPU (PC, A, B, carry, registered output port).
// One instruction executes per enabled clock; the instruction word comes
// combinationally from an external ROM addressed by the PC.
// Optional feature macro: CPU4_HALT_EN (opcode 1111 halts the core until reset).
module cpu4_core #(
    parameter logic [3:0] RESET_PC  = 4'h0,
    parameter logic [3:0] OUT_RESET = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [3:0] rom_addr,
    input  logic [3:0] rom_opcode,
    input  logic [3:0] rom_imdata,
    input  logic [3:0] in_port,
    output logic [3:0] out_port,
    output logic       out_valid,
    output logic       carry,
    output logic       halted
);

    typedef enum logic [3:0] {
        OP_ADD_A = 4'h0,
        OP_ADD_B = 4'h1,
        OP_MOV_A = 4'h2,
        OP_MOV_B = 4'h3,
        OP_MOV_AB = 4'h4,
        OP_MOV_BA = 4'h5,
        OP_IN_A  = 4'h6,
        OP_IN_B  = 4'h7,
        OP_OUT_A = 4'h8,
        OP_OUT_B = 4'h9,
        OP_OUT_I = 4'hA,
        OP_JMP   = 4'hC,
        OP_JNC   = 4'hD,
        OP_HALT  = 4'hF
    } op_e;

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } state_e;

    logic [3:0] pc_q, pc_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic       carry_q, carry_d;
    logic [3:0] out_q, out_d;
    logic       valid_q, valid_d;
    state_e     state_q, state_d;
    op_e        op;

    assign op        = op_e'(rom_opcode);
    assign rom_addr  = pc_q;
    assign out_port  = out_q;
    assign out_valid = valid_q;
    assign carry     = carry_q;

`ifdef CPU4_HALT_EN
    assign halted = (state_q == ST_HALT);
`else
    assign halted = 1'b0;
`endif

    // Decode and execute the current instruction into next-state values.
    always_comb begin
        pc_d    = pc_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        out_d   = out_q;
        valid_d = 1'b0;
        state_d = state_q;
        if (en && (state_q == ST_RUN)) begin
            pc_d    = pc_q + 4'd1;
            carry_d = 1'b0;
            case (op)
                OP_ADD_A:  {carry_d, a_d} = {1'b0, a_q} + {1'b0, rom_imdata};
                OP_ADD_B:  {carry_d, b_d} = {1'b0, b_q} + {1'b0, rom_imdata};
                OP_MOV_A:  a_d = rom_imdata;
                OP_MOV_B:  b_d = rom_imdata;
                OP_MOV_AB: a_d = b_q;
                OP_MOV_BA: b_d = a_q;
                OP_IN_A:   a_d = in_port;
                OP_IN_B:   b_d = in_port;
                OP_OUT_A: begin
                    out_d   = a_q;
                    valid_d = 1'b1;
                end
                OP_OUT_B: begin
                    out_d   = b_q;
                    valid_d = 1'b1;
                end
                OP_OUT_I: begin
                    out_d   = rom_imdata;
                    valid_d = 1'b1;
                end
                OP_JMP:    pc_d = rom_imdata;
                // JNC looks at the carry held before this instruction.
                OP_JNC: begin
                    if (!carry_q) pc_d = rom_imdata;
                end
`ifdef CPU4_HALT_EN
                OP_HALT: begin
                    pc_d    = pc_q;
                    carry_d = carry_q;
                    state_d = ST_HALT;
                end
`endif
                default: ;
            endcase
        end
    end

    // Architectural state registers; reset discards the instruction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            out_q   <= OUT_RESET;
            valid_q <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            pc_q    <= pc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_cpu4_core.sv
// Self-checking bench for cpu4_core: directed programs plus a random program,
// all checked against a behavioural instruction-level model.
module tb_cpu4_core;

    localparam logic [3:0] RPC  = 4'h0;
    localparam logic [3:0] ORST = 4'hA;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [3:0] rom_addr, rom_opcode, rom_imdata, in_port, out_port;
    logic       out_valid, carry, halted;

    logic [7:0] rom [16];
    logic [3:0] outs [$];
    logic [3:0] std_seq [6];

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_pc, m_a, m_b, m_c, m_out, m_valid, m_halt;

    cpu4_core #(.RESET_PC(RPC), .OUT_RESET(ORST)) dut (
        .clk(clk), .rst(rst), .en(en),
        .rom_addr(rom_addr), .rom_opcode(rom_opcode), .rom_imdata(rom_imdata),
        .in_port(in_port), .out_port(out_port), .out_valid(out_valid),
        .carry(carry), .halted(halted)
    );

    always #5 clk = ~clk;

    assign rom_opcode = rom[rom_addr][7:4];
    assign rom_imdata = rom[rom_addr][3:0];

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit e, input int inp);
        int op, im, s, npc, nc;
        if (r) begin
            m_pc = int'(RPC); m_a = 0; m_b = 0; m_c = 0;
            m_out = int'(ORST); m_valid = 0; m_halt = 0;
            return;
        end
        m_valid = 0;
        if (!e || m_halt != 0) return;
        op  = int'(rom[m_pc][7:4]);
        im  = int'(rom[m_pc][3:0]);
        npc = (m_pc + 1) % 16;
        nc  = 0;
        case (op)
            0:  begin s = m_a + im; m_a = s % 16; nc = s / 16; end
            1:  begin s = m_b + im; m_b = s % 16; nc = s / 16; end
            2:  m_a = im;
            3:  m_b = im;
            4:  m_a = m_b;
            5:  m_b = m_a;
            6:  m_a = inp;
            7:  m_b = inp;
            8:  begin m_out = m_a; m_valid = 1; end
            9:  begin m_out = m_b; m_valid = 1; end
            10: begin m_out = im;  m_valid = 1; end
            12: npc = im;
            13: if (m_c == 0) npc = im;
`ifdef CPU4_HALT_EN
            15: begin m_halt = 1; npc = m_pc; nc = m_c; end
`endif
            default: ;
        endcase
        m_pc = npc;
        m_c  = nc;
    endtask

    task automatic cycle(input bit r, input bit e, input logic [3:0] inp);
        rst = r; en = e; in_port = inp;
        model_edge(r, e, int'(inp));
        @(posedge clk);
        #1;
        chk("rom_addr",  rom_addr,           4'(m_pc));
        chk("out_port",  out_port,           4'(m_out));
        chk("out_valid", {3'b0, out_valid},  4'(m_valid));
        chk("carry",     {3'b0, carry},      4'(m_c));
        chk("halted",    {3'b0, halted},     4'(m_halt));
        if (out_valid === 1'b1) outs.push_back(out_port);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b1, 4'h0);
        cycle(1'b1, 1'b1, 4'h0);
        outs.delete();
    endtask

    task automatic check_std_outs(input string tag);
        chk({tag, "_count"}, 4'(outs.size()), 4'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < outs.size()) chk(tag, outs[i], std_seq[i]);
            else                 chk(tag, 4'hX, std_seq[i]);
        end
    endtask

    initial begin
        std_seq = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd4, 4'd0};
        rst = 1'b1; en = 1'b1; in_port = 4'h0;

        // Standard program: MOV A,1; OUT A; ADD A,1; OUT A; ADD A,2; OUT A;
        // ADD A,4; OUT A; OUT 4; OUT 0; MOV B,A; ADD A,0 x5
        rom = '{8'h21, 8'h80, 8'h01, 8'h80, 8'h02, 8'h80, 8'h04, 8'h80,
                8'hA4, 8'hA0, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        // Reset state
        do_reset();
        chk("rst_pc",    rom_addr,          4'h0);
        chk("rst_out",   out_port,          ORST);
        chk("rst_valid", {3'b0, out_valid}, 4'h0);
        chk("rst_carry", {3'b0, carry},     4'h0);
        chk("rst_halt",  {3'b0, halted},    4'h0);

        // Standard program, one full pass and PC wrap
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 4'h0);
        check_std_outs("std_seq");
        chk("wrap_pc",    rom_addr,      4'h0);
        chk("wrap_carry", {3'b0, carry}, 4'h0);

        // en gating mid-program
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 4'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 4'h0);
            chk("frozen_pc",    rom_addr,          4'h4);
            chk("frozen_valid", {3'b0, out_valid}, 4'h0);
        end
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 4'h0);
        check_std_outs("gated_seq");

        // Carry / JNC
        rom = '{8'h2F, 8'h01, 8'hD5, 8'hD5, 8'hB0, 8'h80, 8'hC6, 8'hB0,
                8'hB0, 8'hB0, 8'hB0, 8'hB0, 8'hB0, 8'hB0, 8'hB0, 8'hB0};
        do_reset();
        cycle(1'b0, 1'b1, 4'h0);
        cycle(1'b0, 1'b1, 4'h0);
        chk("add_carry", {3'b0, carry}, 4'h1);
        cycle(1'b0, 1'b1, 4'h0);
        chk("jnc_fall_pc",    rom_addr,      4'h3);
        chk("jnc_fall_carry", {3'b0, carry}, 4'h0);
        cycle(1'b0, 1'b1, 4'h0);
        chk("jnc_take_pc", rom_addr, 4'h5);
        cycle(1'b0, 1'b1, 4'h0);
        chk("wrapped_a", out_port, 4'h0);
        chk("wrapped_a_valid", {3'b0, out_valid}, 4'h1);

        // IN / MOV / OUT B
        rom = '{8'h60, 8'h50, 8'h90, 8'hC3, 8'hB0, 8'hB0, 8'hB0, 8'hB0,
                8'hB0, 8'hB0, 8'hB0, 8'hB0, 8'hB0, 8'hB0, 8'hB0, 8'hB0};
        do_reset();
        cycle(1'b0, 1'b1, 4'h9);
        cycle(1'b0, 1'b1, 4'h0);
        cycle(1'b0, 1'b1, 4'h0);
        chk("in_out_val", out_port, 4'h9);
        cycle(1'b0, 1'b1, 4'h0);
        cycle(1'b0, 1'b1, 4'h0);
        chk("in_out_pulses", 4'(outs.size()), 4'd1);

        // HALT at address 3
        rom = '{8'hB0, 8'hB0, 8'hB0, 8'hF0, 8'hB0, 8'hB0, 8'hB0, 8'hB0,
                8'hB0, 8'hB0, 8'hB0, 8'hB0, 8'hB0, 8'hB0, 8'hB0, 8'hB0};
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 4'h0);
`ifdef CPU4_HALT_EN
        chk("halt_pc",   rom_addr,       4'h3);
        chk("halt_flag", {3'b0, halted}, 4'h1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 4'h0);
        chk("halt_hold_pc", rom_addr, 4'h3);
`else
        chk("halt_nop_pc", rom_addr,       4'h4);
        chk("halt_nop_fl", {3'b0, halted}, 4'h0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 4'h0);
        chk("halt_nop_pc2", rom_addr, 4'h7);
`endif
        cycle(1'b1, 1'b1, 4'h0);
        chk("halt_rst_pc",   rom_addr,       4'h0);
        chk("halt_rst_flag", {3'b0, halted}, 4'h0);

        // Random program, random en / in_port / occasional reset
        for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                  4'($urandom));
            if (i % 100 == 99) begin
                for (int j = 0; j < 16; j++) rom[j] = 8'($urandom);
                do_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
